inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Parametrised dual-issue instruction queue between the fetch stage and the decode/issue stage.
- Accepts up to PUSH_N instruction/PC pairs per cycle from fetch.
- Presents the two oldest entries to a dual-issue decoder, which dequeues 0, 1 or 2 per cycle.
- Adds over the single-write/pair-read buffer: multi-lane push, variable dequeue, simultaneous push/pop, backpressure with margin, and same-cycle visible outputs.

Parameters:
- DEPTH, 16: number of entries; power of two, at least 2*PUSH_N.
- DATA_W, 32: instruction width.
- ADDR_W, 32: instruction address width.
- PUSH_N, 2: fetch lanes per cycle; 1, 2 or 4.

Ports:
- clk, in, 1: clock; all state updates on its rising edge.
- resetn, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous queue clear (branch mispredict / exception).
- push_valid, in, PUSH_N: per-lane valid; lane 0 is the oldest; must be contiguous from lane 0.
- push_inst, in, PUSH_N*DATA_W: packed instructions; lane k is at bits [k*DATA_W +: DATA_W].
- push_addr, in, PUSH_N*ADDR_W: packed PCs, same packing as push_inst.
- push_ready, out, 1: high when free entries >= PUSH_N.
- out_valid, out, 2: bit0 = head entry valid, bit1 = head+1 entry valid.
- out_inst0 / out_inst1, out, DATA_W: head and head+1 instructions.
- out_addr0 / out_addr1, out, ADDR_W: head and head+1 PCs.
- deq_cnt, in, 2: number of entries the consumer takes this cycle (0..2).
- count, out, clog2(DEPTH)+1: current occupancy.
- full, out, 1: count == DEPTH.

Behaviour:
- Reset: resetn low asynchronously clears head, tail and count to 0.
  - Consequently out_valid = 0, all out_inst/out_addr = 0, push_ready = 1, full = 0.
  - Storage contents are not cleared.
- Pointers: head and tail are clog2(DEPTH) bits and wrap naturally modulo DEPTH; count carries one extra bit.
- Outputs are combinational from head and count; there is no output register stage.
  - An entry pushed at edge N is visible at out_* after edge N, in the same cycle it becomes available.
  - Any lane whose out_valid bit is 0 drives zero on its inst/addr.
- Push:
  - n_push = number of set push_valid bits when the pattern is contiguous; 0 for a non-contiguous pattern (e.g. 2'b10), which is also flagged by a simulation assertion.
  - The push is accepted only when push_ready = 1; otherwise the lanes are dropped, and fetch must hold them.
  - Lane k is written to tail+k; tail advances by n_push.
  - push_ready depends only on the registered count, never on deq_cnt, so there is no combinational path from deq_cnt to push_ready.
- Dequeue:
  - n_pop = min(deq_cnt, number of set out_valid bits); deq_cnt = 3 is treated as 2.
  - Over-request is clipped and flagged by a simulation assertion.
  - head advances by n_pop.
- Simultaneous push and pop: count_next = count + n_push - n_pop.
  - Pushing into an empty queue while deq_cnt > 0 pops nothing that cycle (out_valid was 0).
- Flush: has priority over push and pop in the same cycle.
  - Next state: head = tail = count = 0; out_valid = 0 the following cycle.
  - Push lanes presented in the flush cycle are discarded.
- Full: at count == DEPTH, push_ready = 0 and a dequeue still proceeds.
  - push_ready becomes 1 again only once DEPTH - count >= PUSH_N.
- Wrap-around: a push spanning index DEPTH-1 to 0 places lanes correctly, and out_inst1 reads index 0 when head = DEPTH-1.

Optional Feature:
- Macro: INST_QUEUE_SINGLE_ISSUE_EN.
- Defined: out_valid reflects occupancy exactly; count == 1 gives out_valid = 2'b01, so a single leftover instruction can issue alone.
- Undefined: pair-only issue. out_valid = 2'b11 when count >= 2, else 2'b00; n_pop is either 0 or 2, and deq_cnt = 1 is treated as 0.

Decomposition:
- Shared package inst_queue_pkg:
  - DATA_W / ADDR_W defaults.
  - Pointer and count width functions built on clog2.
  - A deq_cnt encoding enum: DEQ_NONE = 0, DEQ_ONE = 1, DEQ_TWO = 2.
- Sub-module inst_queue_ram: DEPTH x (DATA_W + ADDR_W) storage with PUSH_N write ports and 2 asynchronous read ports.
- inst_queue top owns pointers, count, flush handling and output masking.

Test Plan:
- Reset, then push 2'b11 with PCs 0x1000/0x1004 → next cycle out_valid = 2'b11, out_addr0 = 0x1000, out_addr1 = 0x1004, count = 2.
- Fill 16 entries (8 pushes of 2) → full = 1, push_ready = 0; a ninth push is dropped; deq_cnt = 2 gives count = 14 and push_ready = 1 next cycle.
- At count = 6, push 2 and deq 2 in the same cycle → count stays 6, and the FIFO order of PCs is preserved across the tail wrap at index 15 → 0.
- Count = 1, deq_cnt = 1:
  - Macro defined → out_valid = 2'b01, count goes to 0.
  - Macro undefined → out_valid = 2'b00, count stays 1.
- At count = 9, assert flush together with a 2-lane push and deq_cnt = 2 → next cycle count = 0, out_valid = 0, and the pushed PCs never appear.
- Pull resetn low mid-stream between clock edges → outputs zero immediately, with no clk edge required; after release, the first push is visible at the head.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the dual-issue instruction queue: default widths,
// pointer/count width helpers and the dequeue-count encoding.
package inst_queue_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 32;

   // Ring pointer width; wraps naturally modulo a power-of-two depth.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Occupancy width; one extra bit so a full queue is representable.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   typedef enum logic [1:0] {
      DEQ_NONE = 2'd0,
      DEQ_ONE  = 2'd1,
      DEQ_TWO  = 2'd2
   } deq_e;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode-side bundle of the instruction queue.
// master = fetch + decoder side, slave = the queue itself.
interface inst_queue_if
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned PUSH_N = 2
);
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [PUSH_N-1:0]        push_valid;
   logic [PUSH_N*DATA_W-1:0] push_inst;
   logic [PUSH_N*ADDR_W-1:0] push_addr;
   logic                     push_ready;
   logic [1:0]               out_valid;
   logic [DATA_W-1:0]        out_inst0;
   logic [DATA_W-1:0]        out_inst1;
   logic [ADDR_W-1:0]        out_addr0;
   logic [ADDR_W-1:0]        out_addr1;
   logic [1:0]               deq_cnt;
   logic [CW-1:0]            count;
   logic                     full;

   modport master (
      output push_valid, push_inst, push_addr, deq_cnt,
      input  push_ready, out_valid, out_inst0, out_inst1,
             out_addr0, out_addr1, count, full
   );

   modport slave (
      input  push_valid, push_inst, push_addr, deq_cnt,
      output push_ready, out_valid, out_inst0, out_inst1,
             out_addr0, out_addr1, count, full
   );

endinterface

// File: rtl/inst_queue_ram.sv
// Entry storage for the instruction queue: DEPTH x {addr, inst},
// PUSH_N write ports and two asynchronous read ports. Not reset.
module inst_queue_ram
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned PUSH_N = 2,
   localparam int unsigned PW    = ptr_w(DEPTH),
   localparam int unsigned EW    = DATA_W + ADDR_W
) (
   input  logic                 clk,
   input  logic [PUSH_N-1:0]    wr_en,
   input  logic [PUSH_N*PW-1:0] wr_idx,
   input  logic [PUSH_N*EW-1:0] wr_data,
   input  logic [PW-1:0]        rd_idx0,
   input  logic [PW-1:0]        rd_idx1,
   output logic [EW-1:0]        rd_data0,
   output logic [EW-1:0]        rd_data1
);

   logic [EW-1:0] mem [DEPTH];

   // Lanes always target distinct indices, so write order does not matter
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < PUSH_N; k++) begin
         if (wr_en[k]) begin
            mem[wr_idx[k*PW +: PW]] <= wr_data[k*EW +: EW];
         end
      end
   end

   assign rd_data0 = mem[rd_idx0];
   assign rd_data1 = mem[rd_idx1];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode.
// Multi-lane push, 0/1/2 dequeue per cycle, combinational head window.
// Optional: INST_QUEUE_SINGLE_ISSUE_EN lets a lone head entry issue by
// itself; without it the decoder only ever sees and takes pairs.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned PUSH_N = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   inst_queue_if.slave iq
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);
   localparam int unsigned EW = DATA_W + ADDR_W;

   logic [PW-1:0]        head;
   logic [PW-1:0]        tail;
   logic [CW-1:0]        count;
   logic [CW-1:0]        n_push_raw;
   logic [CW-1:0]        n_push;
   logic [CW-1:0]        n_req;
   logic [CW-1:0]        n_avail;
   logic [CW-1:0]        n_pop;
   logic                 contig;
   logic                 gap;
   logic                 ready;
   logic [1:0]           valid;
   logic [PUSH_N-1:0]    wr_en;
   logic [PUSH_N*PW-1:0] wr_idx;
   logic [PUSH_N*EW-1:0] wr_data;
   logic [EW-1:0]        rd0;
   logic [EW-1:0]        rd1;

   // Registered occupancy only, keeping deq_cnt off the push_ready path
   assign ready = (count <= CW'(DEPTH - PUSH_N));

   // Count contiguous push lanes; a holed pattern pushes nothing
   always_comb begin
      n_push_raw = '0;
      contig     = 1'b1;
      gap        = 1'b0;
      for (int unsigned k = 0; k < PUSH_N; k++) begin
         if (iq.push_valid[k]) begin
            if (gap) contig = 1'b0;
            n_push_raw = n_push_raw + CW'(1);
         end else begin
            gap = 1'b1;
         end
      end
      n_push = (ready && contig) ? n_push_raw : '0;
   end

   // Lane k lands at tail+k; pointer arithmetic wraps modulo DEPTH
   always_comb begin
      wr_en   = '0;
      wr_idx  = '0;
      wr_data = '0;
      for (int unsigned k = 0; k < PUSH_N; k++) begin
         wr_en[k]              = iq.push_valid[k] && ready && contig && !flush;
         wr_idx[k*PW +: PW]    = tail + PW'(k);
         wr_data[k*EW +: EW]   = {iq.push_addr[k*ADDR_W +: ADDR_W],
                                  iq.push_inst[k*DATA_W +: DATA_W]};
      end
   end

   // Issue window and clipped dequeue amount
   always_comb begin
`ifdef INST_QUEUE_SINGLE_ISSUE_EN
      valid = {count >= CW'(2), count >= CW'(1)};
`else
      valid = (count >= CW'(2)) ? 2'b11 : 2'b00;
`endif
      n_avail = CW'(valid[0]) + CW'(valid[1]);
      case (deq_e'(iq.deq_cnt))
         DEQ_NONE: n_req = '0;
`ifdef INST_QUEUE_SINGLE_ISSUE_EN
         DEQ_ONE:  n_req = CW'(1);
`else
         DEQ_ONE:  n_req = '0;
`endif
         default:  n_req = CW'(2);
      endcase
      n_pop = (n_req > n_avail) ? n_avail : n_req;
   end

   // Pointer/occupancy state; flush wins over push and pop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(n_pop);
         tail  <= tail + PW'(n_push);
         count <= count + n_push - n_pop;
      end
   end

   inst_queue_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .PUSH_N (PUSH_N)
   ) u_ram (
      .clk      (clk),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .rd_idx0  (head),
      .rd_idx1  (head + PW'(1)),
      .rd_data0 (rd0),
      .rd_data1 (rd1)
   );

   assign iq.out_valid  = valid;
   assign iq.out_inst0  = valid[0] ? rd0[DATA_W-1:0]  : '0;
   assign iq.out_addr0  = valid[0] ? rd0[EW-1:DATA_W] : '0;
   assign iq.out_inst1  = valid[1] ? rd1[DATA_W-1:0]  : '0;
   assign iq.out_addr1  = valid[1] ? rd1[EW-1:DATA_W] : '0;
   assign iq.push_ready = ready;
   assign iq.count      = count;
   assign iq.full       = (count == CW'(DEPTH));

   a_push_contig: assert property (@(posedge clk) disable iff (!resetn) contig)
      else $error("inst_queue: non-contiguous push_valid pattern");

   a_deq_in_range: assert property (@(posedge clk) disable iff (!resetn || flush)
                                    n_req <= n_avail)
      else $error("inst_queue: dequeue request exceeds visible entries");

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned DW     = 32;
   localparam int unsigned AW     = 32;
   localparam int unsigned PUSH_N = 2;
`ifdef INST_QUEUE_SINGLE_ISSUE_EN
   localparam bit SINGLE = 1'b1;
`else
   localparam bit SINGLE = 1'b0;
`endif

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic flush  = 1'b0;
   always #5 clk = ~clk;

   inst_queue_if #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW), .PUSH_N(PUSH_N)) bus ();

   inst_queue #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW), .PUSH_N(PUSH_N)) dut (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .iq     (bus)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] addr;
   } ent_t;

   typedef struct {
      logic [1:0]  pv;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic [1:0]  dq;
      logic        fl;
      int          ecount;
      logic [1:0]  evalid;
      logic [31:0] ea0;
      logic [31:0] ea1;
   } vec_t;

   ent_t mq[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return ~pc ^ 32'h1357_0000;
   endfunction

   // Reference: what the decoder may see given the current occupancy
   function automatic logic [1:0] m_valid();
      if (mq.size() >= 2) return 2'b11;
      if (mq.size() == 1 && SINGLE) return 2'b01;
      return 2'b00;
   endfunction

   // Reference: one clock of queue behaviour (pop from old head, then append)
   task automatic model_step(input logic [1:0] pv, input logic [31:0] pc0, input logic [31:0] pc1,
                             input logic [1:0] dq, input logic fl);
      int avail, req, npop;
      logic [1:0] v;
      bit rdy;
      if (fl) begin
         mq.delete();
         return;
      end
      v     = m_valid();
      avail = int'(v[0]) + int'(v[1]);
      req   = (dq == 2'd3) ? 2 : int'(dq);
      if (!SINGLE && req == 1) req = 0;
      npop  = (req < avail) ? req : avail;
      rdy   = (int'(DEPTH) - mq.size()) >= int'(PUSH_N);
      repeat (npop) void'(mq.pop_front());
      if (rdy) begin
         if (pv[0]) mq.push_back('{inst: inst_of(pc0), addr: pc0});
         if (pv[1]) mq.push_back('{inst: inst_of(pc1), addr: pc1});
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [1:0]  v;
      logic [31:0] ei0, ea0, ei1, ea1;
      v   = m_valid();
      ei0 = '0; ea0 = '0; ei1 = '0; ea1 = '0;
      if (v[0]) begin ei0 = mq[0].inst; ea0 = mq[0].addr; end
      if (v[1]) begin ei1 = mq[1].inst; ea1 = mq[1].addr; end
      chk({tag, " count"}, 32'(bus.count), mq.size());
      chk({tag, " full"}, 32'(bus.full), 32'(mq.size() == int'(DEPTH)));
      chk({tag, " push_ready"}, 32'(bus.push_ready),
          32'((int'(DEPTH) - mq.size()) >= int'(PUSH_N)));
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(v));
      chk({tag, " out_inst0"}, bus.out_inst0, ei0);
      chk({tag, " out_addr0"}, bus.out_addr0, ea0);
      chk({tag, " out_inst1"}, bus.out_inst1, ei1);
      chk({tag, " out_addr1"}, bus.out_addr1, ea1);
   endtask

   // Drive one cycle, advance the model, then check one ns after the edge
   task automatic cycle(input string tag, input logic [1:0] pv, input logic [31:0] pc0,
                        input logic [31:0] pc1, input logic [1:0] dq, input logic fl);
      bus.push_valid = pv;
      bus.push_addr  = {pc1, pc0};
      bus.push_inst  = {inst_of(pc1), inst_of(pc0)};
      bus.deq_cnt    = dq;
      flush          = fl;
      model_step(pv, pc0, pc1, dq, fl);
      @(posedge clk);
      #1;
      bus.push_valid = '0;
      bus.deq_cnt    = '0;
      flush          = 1'b0;
      check_all(tag);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < int'(DEPTH) && mq.size() >= 2; i++) begin
         cycle(tag, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
      end
   endtask

   vec_t tbl[8];

   initial begin
      bus.push_valid = '0;
      bus.push_inst  = '0;
      bus.push_addr  = '0;
      bus.deq_cnt    = '0;

      tbl[0] = '{2'b11, 32'h1000, 32'h1004, 2'd0, 1'b0, 2, 2'b11, 32'h1000, 32'h1004};
      tbl[1] = '{2'b11, 32'h1008, 32'h100c, 2'd2, 1'b0, 2, 2'b11, 32'h1008, 32'h100c};
      tbl[2] = '{2'b00, 32'h0,    32'h0,    2'd0, 1'b0, 2, 2'b11, 32'h1008, 32'h100c};
      tbl[3] = '{2'b11, 32'h1010, 32'h1014, 2'd0, 1'b0, 4, 2'b11, 32'h1008, 32'h100c};
      tbl[4] = '{2'b00, 32'h0,    32'h0,    2'd3, 1'b0, 2, 2'b11, 32'h1010, 32'h1014};
      tbl[5] = '{2'b11, 32'h1018, 32'h101c, 2'd2, 1'b1, 0, 2'b00, 32'h0,    32'h0};
      tbl[6] = '{2'b11, 32'h1020, 32'h1024, 2'd0, 1'b0, 2, 2'b11, 32'h1020, 32'h1024};
      tbl[7] = '{2'b00, 32'h0,    32'h0,    2'd2, 1'b0, 0, 2'b00, 32'h0,    32'h0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_all("reset");

      // Table vectors
      for (int i = 0; i < 8; i++) begin
         cycle($sformatf("vec%0d", i), tbl[i].pv, tbl[i].pc0, tbl[i].pc1, tbl[i].dq, tbl[i].fl);
         chk($sformatf("vec%0d tbl count", i), 32'(bus.count), tbl[i].ecount);
         chk($sformatf("vec%0d tbl valid", i), 32'(bus.out_valid), 32'(tbl[i].evalid));
         chk($sformatf("vec%0d tbl addr0", i), bus.out_addr0, tbl[i].ea0);
         chk($sformatf("vec%0d tbl addr1", i), bus.out_addr1, tbl[i].ea1);
      end

      // Fill to full, dropped push, dequeue from full
      for (int i = 0; i < 8; i++) begin
         cycle("fill", 2'b11, 32'h2000 + 32'(8*i), 32'h2004 + 32'(8*i), 2'd0, 1'b0);
      end
      chk("full flag", 32'(bus.full), 32'd1);
      chk("full ready", 32'(bus.push_ready), 32'd0);
      cycle("ninth", 2'b11, 32'h9990, 32'h9994, 2'd0, 1'b0);
      chk("ninth count", 32'(bus.count), 32'd16);
      cycle("deq_full", 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
      chk("deq_full count", 32'(bus.count), 32'd14);
      chk("deq_full ready", 32'(bus.push_ready), 32'd1);
      drain("drain_full");

      // Steady push+pop at count 6 across the 15->0 tail wrap
      cycle("flush_a", 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle("wrap_fill", 2'b11, 32'h3000 + 32'(8*i), 32'h3004 + 32'(8*i), 2'd0, 1'b0);
      end
      cycle("wrap_pop", 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
      cycle("wrap_pop", 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle("wrap_pp", 2'b11, 32'h3100 + 32'(8*i), 32'h3104 + 32'(8*i), 2'd2, 1'b0);
         chk("wrap_pp count", 32'(bus.count), 32'd6);
      end
      drain("wrap_drain");

      // Lone leftover entry
      cycle("flush_b", 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
      cycle("single", 2'b01, 32'h4000, 32'h0, 2'd0, 1'b0);
      chk("single valid", 32'(bus.out_valid), SINGLE ? 32'd1 : 32'd0);
      chk("single count", 32'(bus.count), 32'd1);
      cycle("single_deq", 2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
      chk("single_deq count", 32'(bus.count), SINGLE ? 32'd0 : 32'd1);
      chk("single_deq valid", 32'(bus.out_valid), 32'd0);

      // Flush beats simultaneous push and pop
      cycle("flush_c", 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
      cycle("nine", 2'b01, 32'h5000, 32'h0, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle("nine", 2'b11, 32'h5010 + 32'(8*i), 32'h5014 + 32'(8*i), 2'd0, 1'b0);
      end
      chk("nine count", 32'(bus.count), 32'd9);
      cycle("flush_pp", 2'b11, 32'hBAD0, 32'hBAD4, 2'd2, 1'b1);
      chk("flush_pp count", 32'(bus.count), 32'd0);
      chk("flush_pp valid", 32'(bus.out_valid), 32'd0);
      cycle("post_flush", 2'b11, 32'h5100, 32'h5104, 2'd0, 1'b0);
      chk("post_flush addr0", bus.out_addr0, 32'h5100);
      chk("post_flush addr1", bus.out_addr1, 32'h5104);

      // Asynchronous reset between edges
      cycle("pre_arst", 2'b11, 32'h5200, 32'h5204, 2'd0, 1'b0);
      #3;
      resetn = 1'b0;
      #1;
      mq.delete();
      check_all("arst");
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      cycle("post_arst", 2'b11, 32'h6000, 32'h6004, 2'd0, 1'b0);
      chk("post_arst addr0", bus.out_addr0, 32'h6000);

      // Randomized traffic against the reference queue
      for (int n = 0; n < 600; n++) begin
         logic [1:0] pv, dq, v;
         logic       fl;
         int         avail, req;
         case ($urandom_range(0, 2))
            0:       pv = 2'b00;
            1:       pv = 2'b01;
            default: pv = 2'b11;
         endcase
         dq    = 2'($urandom_range(0, 3));
         fl    = ($urandom_range(0, 31) == 0);
         v     = m_valid();
         avail = int'(v[0]) + int'(v[1]);
         req   = (dq == 2'd3) ? 2 : int'(dq);
         if (!SINGLE && req == 1) req = 0;
         if (req > avail) dq = 2'(avail);
         cycle("rand", pv, $urandom, $urandom, dq, fl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
